// File: rtl/pipelined_cla_adder.sv
// ----------------------------------------------------------------------------
// pipelined_cla_adder
//
// Two-stage pipelined carry-lookahead adder/subtractor with a valid/ready
// handshake on both sides and a sideband tag that travels with each operation.
//
//   Stage 1: effective operand b' (inverted for subtract), per-bit
//            propagate/generate and per-4-bit-group P/G, registered with the
//            carry-in and the tag.
//   Stage 2: group carries from a second lookahead level (groups of four
//            groups) plus a third level across the 16-bit super-groups. Bit
//            carries come from each group's own carry-in, so no carry ever
//            ripples across a 4-bit group boundary. Sum, carry-out, signed
//            overflow, zero flag and tag are registered and drive the outputs.
//
// Ports
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   in_valid/ready   input handshake; in_ready may follow out_ready in the
//                    same cycle
//   in_a, in_b       operands (WIDTH bits)
//   in_cin           carry-in, add mode only
//   in_sub           1 = a - b, 0 = a + b + cin
//   in_tag           opaque tag returned with the result
//   flush            synchronous kill of everything in flight
//   out_valid/ready  output handshake; out_* hold steady while stalled
//   out_sum          sum or difference
//   out_cout         carry out of the MSB (subtract: 1 = no borrow)
//   out_ovf          signed two's-complement overflow
//   out_zero         out_sum is all zeros
//   out_tag          tag of the result
// ----------------------------------------------------------------------------
module pipelined_cla_adder #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NG = WIDTH / 4;  // 4-bit groups
  localparam int NS = NG / 4;     // 16-bit super-groups

  // Carries into the four positions of a lookahead block, given the P/G of
  // the lower three positions and the block carry-in. Fully flattened
  // sum-of-products, no chaining between positions.
  function automatic logic [3:0] lac4(input logic [2:0] p, input logic [2:0] g, input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  // Group generate of a 4-wide block; p_hi holds propagate of positions 3..1.
  function automatic logic grp_g(input logic [2:0] p_hi, input logic [3:0] g);
    return g[3] | (p_hi[2] & g[2]) | (p_hi[2] & p_hi[1] & g[1]) |
           (p_hi[2] & p_hi[1] & p_hi[0] & g[0]);
  endfunction

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic r_s1_valid;
  logic r_s2_valid;
  logic w_s2_open;   // stage 2 is empty or hands its result over this cycle
  logic w_s1_load;   // stage 1 captures a new operation
  logic w_s1_adv;    // stage 1 contents move into stage 2
  logic w_s2_load;   // stage 2 captures stage 1 contents

  // Pipeline control: load conditions and input ready
  always_comb begin
    w_s2_open = ~r_s2_valid | out_ready;
    w_s1_adv  = r_s1_valid & w_s2_open;
    w_s2_load = w_s1_adv & ~flush;
    w_s1_load = in_valid & ~flush & (~r_s1_valid | w_s2_open);
    // Valid bits are already cleared during reset; the reset_n term only
    // keeps in_ready low while reset is held.
    in_ready  = reset_n & ~flush & (~r_s1_valid | w_s2_open);
  end

  // Valid bits: async clear on reset, synchronous clear on flush
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= 1'b1;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end else begin
        r_s1_valid <= r_s1_valid;
      end
      if (w_s2_open) begin
        r_s2_valid <= r_s1_valid;
      end else begin
        r_s2_valid <= r_s2_valid;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: effective operands, bit and group propagate/generate
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic             w_c0;
  logic [NG-1:0]    w_gp;
  logic [NG-1:0]    w_gg;

  // Subtract is a + ~b + 1
  always_comb begin
    w_b_eff = in_sub ? ~in_b : in_b;
    w_c0    = in_sub ? 1'b1 : in_cin;
    w_p     = in_a ^ w_b_eff;
    w_g     = in_a & w_b_eff;
    w_gp    = {NG{1'b0}};
    w_gg    = {NG{1'b0}};
    for (int j = 0; j < NG; j++) begin
      w_gp[j] = &w_p[4*j +: 4];
      w_gg[j] = grp_g(w_p[4*j+1 +: 3], w_g[4*j +: 4]);
    end
  end

  logic [WIDTH-1:0] r_s1_p;
  logic [WIDTH-1:0] r_s1_g;
  logic [NG-1:0]    r_s1_gp;
  logic [NG-1:0]    r_s1_gg;
  logic             r_s1_c0;
  logic [TAG_W-1:0] r_s1_tag;

  // Stage 1 data registers, written only when stage 1 loads
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_p   <= {WIDTH{1'b0}};
      r_s1_g   <= {WIDTH{1'b0}};
      r_s1_gp  <= {NG{1'b0}};
      r_s1_gg  <= {NG{1'b0}};
      r_s1_c0  <= 1'b0;
      r_s1_tag <= {TAG_W{1'b0}};
    end else if (w_s1_load) begin
      r_s1_p   <= w_p;
      r_s1_g   <= w_g;
      r_s1_gp  <= w_gp;
      r_s1_gg  <= w_gg;
      r_s1_c0  <= w_c0;
      r_s1_tag <= in_tag;
    end else begin
      r_s1_p   <= r_s1_p;
      r_s1_g   <= r_s1_g;
      r_s1_gp  <= r_s1_gp;
      r_s1_gg  <= r_s1_gg;
      r_s1_c0  <= r_s1_c0;
      r_s1_tag <= r_s1_tag;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: lookahead carries, sum and flags
  // --------------------------------------------------------------------------
  logic [2:0]       w_top_p;   // super-group P/G feeding the top level
  logic [2:0]       w_top_g;
  logic [3:0]       w_sg_c;    // carry into each super-group
  logic [NG-1:0]    w_gc;      // carry into each group
  logic [WIDTH-1:0] w_c;       // carry into each bit
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic             w_zero;

  // Three lookahead levels: super-group, group, bit. The topmost super-group
  // never feeds a carry-in, so only the lower three form the top level; for
  // narrower widths the unused top-level inputs are tied off.
  always_comb begin
    w_top_p = 3'b000;
    w_top_g = 3'b000;
    w_gc    = {NG{1'b0}};
    w_c     = {WIDTH{1'b0}};
    for (int s = 0; s < 3; s++) begin
      if (s < NS - 1) begin
        w_top_p[s] = &r_s1_gp[4*s +: 4];
        w_top_g[s] = grp_g(r_s1_gp[4*s+1 +: 3], r_s1_gg[4*s +: 4]);
      end else begin
        w_top_p[s] = 1'b0;
        w_top_g[s] = 1'b0;
      end
    end
    w_sg_c = lac4(w_top_p, w_top_g, r_s1_c0);
    for (int s = 0; s < NS; s++) begin
      w_gc[4*s +: 4] = lac4(r_s1_gp[4*s +: 3], r_s1_gg[4*s +: 3], w_sg_c[s]);
    end
    for (int j = 0; j < NG; j++) begin
      w_c[4*j +: 4] = lac4(r_s1_p[4*j +: 3], r_s1_g[4*j +: 3], w_gc[j]);
    end
    w_cout = r_s1_gg[NG-1] | (r_s1_gp[NG-1] & w_gc[NG-1]);
    w_sum  = r_s1_p ^ w_c;
    w_ovf  = w_c[WIDTH-1] ^ w_cout;
    w_zero = ~|w_sum;
  end

  // Each group's top generate bit is already folded into the registered
  // group G, so the bit-level lookahead never reads it.
  logic w_unused_g;

  // Collects those otherwise-unread generate bits
  always_comb begin
    w_unused_g = 1'b0;
    for (int j = 0; j < NG; j++) begin
      w_unused_g = w_unused_g ^ r_s1_g[4*j+3];
    end
  end

  logic [WIDTH-1:0] r_s2_sum;
  logic             r_s2_cout;
  logic             r_s2_ovf;
  logic             r_s2_zero;
  logic [TAG_W-1:0] r_s2_tag;

  // Stage 2 result registers, written only when stage 2 loads
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_sum  <= {WIDTH{1'b0}};
      r_s2_cout <= 1'b0;
      r_s2_ovf  <= 1'b0;
      r_s2_zero <= 1'b0;
      r_s2_tag  <= {TAG_W{1'b0}};
    end else if (w_s2_load) begin
      r_s2_sum  <= w_sum;
      r_s2_cout <= w_cout;
      r_s2_ovf  <= w_ovf;
      r_s2_zero <= w_zero;
      r_s2_tag  <= r_s1_tag;
    end else begin
      r_s2_sum  <= r_s2_sum;
      r_s2_cout <= r_s2_cout;
      r_s2_ovf  <= r_s2_ovf;
      r_s2_zero <= r_s2_zero;
      r_s2_tag  <= r_s2_tag;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_sum   = r_s2_sum;
  assign out_cout  = r_s2_cout;
  assign out_ovf   = r_s2_ovf;
  assign out_zero  = r_s2_zero;
  assign out_tag   = r_s2_tag;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// ----------------------------------------------------------------------------
// tb_pipelined_cla_adder
//
// Scoreboard bench: the driver pushes the expected result of every accepted
// operation into a queue; an independent monitor pops and compares whenever
// an output transfer happens. Directed vectors carry hand-computed results;
// a randomised stream with stalls and a mid-stream reset uses a plain
// arithmetic reference.
// ----------------------------------------------------------------------------
module tb_pipelined_cla_adder;

  localparam int W  = 64;
  localparam int TW = 4;

  logic          clock;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_cin;
  logic          in_sub;
  logic [TW-1:0] in_tag;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          out_ovf;
  logic          out_zero;
  logic [TW-1:0] out_tag;

  pipelined_cla_adder #(.WIDTH(W), .TAG_W(TW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .in_sub   (in_sub),
    .in_tag   (in_tag),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .out_zero (out_zero),
    .out_tag  (out_tag)
  );

  typedef struct packed {
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic          zero;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   out_cycles[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  function automatic exp_t mk(input logic [W-1:0] s, input logic co, input logic ov,
                              input logic z, input logic [TW-1:0] t);
    exp_t e;
    e.sum = s; e.cout = co; e.ovf = ov; e.zero = z; e.tag = t;
    return e;
  endfunction

  // Reference: plain wide addition of the effective operands
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub, input logic [TW-1:0] t);
    logic [W-1:0] bb;
    logic         c0;
    logic [W:0]   full;
    exp_t         e;
    bb     = sub ? ~b : b;
    c0     = sub ? 1'b1 : cin;
    full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    e.zero = (full[W-1:0] == {W{1'b0}});
    e.tag  = t;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic [TW-1:0] t);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_tag = t;
  endtask

  // Offer one operation (called at posedge+1), push expectation on acceptance
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input logic [TW-1:0] t, input exp_t e);
    bit done;
    done = 1'b0;
    set_op(a, b, cin, sub, t);
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clock);
      if (in_ready) begin
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL issue_timeout: tag %0d never accepted, in_ready=%b expected 1", t, in_ready);
    end
  endtask

  // Monitor: checks every output transfer and stability while stalled
  initial begin
    exp_t held_val;
    exp_t cur;
    exp_t e;
    bit   held;
    held = 1'b0;
    forever begin
      @(negedge clock);
      cur = mk(out_sum, out_cout, out_ovf, out_zero, out_tag);
      if (reset_n) begin
        if (held) begin
          n_checks++;
          if (!out_valid || cur !== held_val) begin
            n_errors++;
            $display("FAIL stall_stable: got valid=%b %h, expected valid=1 %h", out_valid, cur, held_val);
          end
        end
        if (out_valid && out_ready) begin
          n_checks++;
          out_cycles.push_back(cyc);
          if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_out: got tag %0d sum %h, expected no output", out_tag, out_sum);
          end else begin
            e = sb.pop_front();
            if (cur !== e) begin
              n_errors++;
              $display("FAIL result: got sum=%h cout=%b ovf=%b zero=%b tag=%0d, expected sum=%h cout=%b ovf=%b zero=%b tag=%0d",
                       out_sum, out_cout, out_ovf, out_zero, out_tag, e.sum, e.cout, e.ovf, e.zero, e.tag);
            end
          end
        end
        held     = out_valid && !out_ready && !flush;
        held_val = cur;
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    set_op(64'd0, 64'd0, 1'b0, 1'b0, 4'd0);

    // Reset state
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_sum", out_sum, 64'd0);
    chk("rst_flags", {out_cout, out_ovf, out_zero}, 3'b000);
    chk("rst_out_tag", out_tag, 4'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("in_ready_after_rst", in_ready, 1'b1);

    // Latency: all-ones + 1 wraps to zero with carry-out
    @(posedge clock);
    #1;
    set_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 4'd3);
    in_valid = 1'b1;
    @(negedge clock);
    chk("lat_accept", in_ready, 1'b1);
    if (in_ready) sb.push_back(mk(64'd0, 1'b1, 1'b0, 1'b1, 4'd3));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(negedge clock);
    chk("lat_cycle1_valid", out_valid, 1'b0);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("lat_cycle2_valid", out_valid, 1'b1);
    @(posedge clock);
    #1;

    // Back-to-back directed vectors, no stalls
    out_cycles.delete();
    issue(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 4'd5, mk(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 4'd5));
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 4'd6, mk(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 4'd6));
    issue(64'd0, 64'd0, 1'b0, 1'b0, 4'd0, mk(64'd0, 1'b0, 1'b0, 1'b1, 4'd0));
    issue(64'd5, 64'd5, 1'b0, 1'b1, 4'd7, mk(64'd0, 1'b1, 1'b0, 1'b1, 4'd7));
    issue(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 4'd8,
          mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 4'd8));
    issue(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, 4'd9,
          mk(64'd0, 1'b1, 1'b0, 1'b1, 4'd9));
    issue(64'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 4'd10, mk(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 4'd10));
    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 4'd11, mk(64'd0, 1'b1, 1'b1, 1'b1, 4'd11));
    issue(64'd3, 64'd1, 1'b1, 1'b1, 4'd12, mk(64'd2, 1'b1, 1'b0, 1'b0, 4'd12));
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clock);
    #1;
    chk("burst_count", out_cycles.size(), 9);
    if (out_cycles.size() == 9) chk("burst_span", out_cycles[8] - out_cycles[0], 8);

    // Backpressure: tags 1,2,3 offered while out_ready is low for 4 cycles
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    set_op(64'd1, 64'd2, 1'b0, 1'b0, 4'd1);
    in_valid = 1'b1;
    @(negedge clock);
    chk("bp_accept1", in_ready, 1'b1);
    if (in_ready) sb.push_back(mk(64'd3, 1'b0, 1'b0, 1'b0, 4'd1));
    @(posedge clock);
    #1;
    set_op(64'd10, 64'd3, 1'b0, 1'b1, 4'd2);
    @(negedge clock);
    chk("bp_accept2", in_ready, 1'b1);
    if (in_ready) sb.push_back(mk(64'd7, 1'b1, 1'b0, 1'b0, 4'd2));
    @(posedge clock);
    #1;
    set_op(64'd0, 64'd1, 1'b0, 1'b1, 4'd3);
    @(negedge clock);
    chk("bp_full_ready", in_ready, 1'b0);
    chk("bp_head_tag", out_tag, 4'd1);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("bp_still_full", in_ready, 1'b0);
    chk("bp_head_sum", out_sum, 64'd3);
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    @(negedge clock);
    chk("bp_release_ready", in_ready, 1'b1);
    if (in_ready) sb.push_back(mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 4'd3));
    chk("bp_out1", {out_valid, out_tag}, {1'b1, 4'd1});
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(negedge clock);
    chk("bp_out2", {out_valid, out_tag}, {1'b1, 4'd2});
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("bp_out3", {out_valid, out_tag}, {1'b1, 4'd3});
    @(posedge clock);
    #1;

    // Flush with both stages full and an input offered in the same cycle
    out_ready = 1'b0;
    set_op(64'd1, 64'd1, 1'b0, 1'b0, 4'd13);
    in_valid = 1'b1;
    @(negedge clock);
    if (in_ready) sb.push_back(mk(64'd2, 1'b0, 1'b0, 1'b0, 4'd13));
    @(posedge clock);
    #1;
    set_op(64'd2, 64'd2, 1'b0, 1'b0, 4'd14);
    @(negedge clock);
    if (in_ready) sb.push_back(mk(64'd4, 1'b0, 1'b0, 1'b0, 4'd14));
    @(posedge clock);
    #1;
    set_op(64'd9, 64'd9, 1'b0, 1'b0, 4'd15);
    flush = 1'b1;
    @(negedge clock);
    chk("flush_in_ready", in_ready, 1'b0);
    chk("flush_pre_out", {out_valid, out_tag}, {1'b1, 4'd13});
    @(posedge clock);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clock);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready_after", in_ready, 1'b1);
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1;

    // Random stream with stalls and a reset pulse in the middle
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      if (i == 200) begin
        in_valid = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_out_sum", out_sum, 64'd0);
        sb.delete();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        chk("midrst_ready_after", in_ready, 1'b1);
        @(posedge clock);
        #1;
      end
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: ra = 64'hFFFF_FFFF_FFFF_FFFF;
        1: rb = 64'h8000_0000_0000_0000;
        2: rb = ra;
        default: ra = ra;
      endcase
      set_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      if (in_valid && in_ready) sb.push_back(model(in_a, in_b, in_cin, in_sub, in_tag));
      @(posedge clock);
      #1;
    end

    // Drain
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clock);
    repeat (3) @(posedge clock);
    #1;
    chk("drain_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
